ram_access_arbiter: RTL
=======================

Name: ram_access_arbiter

Overview:
- Round-robin arbiter that shares one RAM block (separate read/write address ports, registered read data, 1-cycle read latency) between NUM_REQ requesters.
- Serialises accesses to one read or one write per cycle.
- Returns read data to the originating requester with a per-requester valid.
- Contains an init sequencer that sweeps every RAM location to INIT_VALUE on command.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, RAM address width
DATA_WIDTH, 32, RAM data width
DEPTH, 16, number of RAM words swept by init (<= 2**ADDR_WIDTH)
INIT_VALUE, 0, word written to every location during init

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request, held until granted
we  in  NUM_REQ  per-requester 1=write, 0=read
addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing
gnt  out  NUM_REQ  one-hot grant, access performed this cycle
rvalid  out  NUM_REQ  per-requester read-data valid
rdata  out  DATA_WIDTH  read data, shared; qualified by rvalid
init_start  in  1  pulse: begin init sweep
init_busy  out  1  init sweep in progress
init_done  out  1  one-cycle pulse after last init write
ram_raddr  out  ADDR_WIDTH  to RAM raddr
ram_waddr  out  ADDR_WIDTH  to RAM waddr
ram_din  out  DATA_WIDTH  to RAM din
ram_wen  out  1  to RAM wen
ram_ren  out  1  to RAM ren
ram_dout  in  DATA_WIDTH  from RAM dout

Behaviour:
- Reset values: state=ST_ARB, rr_ptr=0, init counter=0, rvalid=0, init_busy=0, init_done=0.
- Reset values, combinational outputs with req=0: gnt=0, ram_wen=0, ram_ren=0, addresses and din=0.
- FSM states:
  - ST_ARB: normal arbitration.
  - ST_INIT: sweep.
  - ST_DONE: single cycle; drives init_done=1, then goes to ST_ARB.
- ST_ARB grant selection (combinational):
  - Search req starting at index rr_ptr, upward with wrap.
  - First set bit wins. gnt is one-hot, or 0 if req==0.
- ST_ARB RAM drive:
  - Winner's we=1: ram_wen=1, ram_waddr/ram_din = winner's addr/wdata.
  - Winner's we=0: ram_ren=1, ram_raddr = winner's addr.
  - The wen and ren outputs are never both 1.
- Pointer update: on any grant, rr_ptr <= (winner+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Read return:
  - rvalid[i] <= gnt[i] & ~we[i] (registered), so rvalid appears the cycle after the grant.
  - rdata = ram_dout passthrough.
  - Back-to-back reads give rvalid every cycle.
- Ordering: a write granted in cycle N is visible to a read granted in cycle N+1 or later.
- init_start handling:
  - Sampled only in ST_ARB. A grant in the same cycle still completes.
  - Next state is ST_INIT, with counter=0.
- ST_INIT:
  - gnt=0 and requests stall.
  - ram_wen=1, ram_waddr=counter, ram_din=INIT_VALUE, init_busy=1.
  - Counter increments each cycle. On counter==DEPTH-1 the next state is ST_DONE.
  - Total init time: DEPTH write cycles plus 1 done cycle.
- init_start during ST_INIT or ST_DONE is ignored.
- Reads issued before init may complete their rvalid in the first ST_INIT cycle. This is legal.
- Reset asserted mid-sweep: immediate return to ST_ARB. Memory is left partially initialised; no init_done.
- Single requester continuously requesting: granted every cycle.
- All requesters continuously requesting: each granted once per NUM_REQ cycles.

Optional Feature:
- Macro: RAM_ARB_LOCK_EN.
- When defined:
  - Adds input lock [NUM_REQ-1:0].
  - If the current winner has req & lock set, a registered lock_owner forces the grant to that requester on the following cycles while its req & lock remain high.
  - rr_ptr does not advance during the lock. It advances past the owner on release.
  - Lock is cleared by reset and by entering ST_INIT. Init still preempts the lock.
- When undefined: no lock port; pure round-robin.

Decomposition:
- Shared package ram_arb_pkg holds:
  - State encoding ST_ARB/ST_INIT/ST_DONE.
  - Default width/depth localparams, shared with the RAM instance.
- One natural sub-module, rr_pick: combinational rotating priority encoder (req, rr_ptr -> one-hot gnt, winner index).

Test Plan:
- Reset: rst_n=0 with req=2'b11 -> gnt=0, rvalid=0, init_busy=0. After release, first grant goes to requester 0.
- Round-robin: req=2'b11 for 4 cycles, all reads -> gnt 01,10,01,10; rvalid follows one cycle later.
- Write then read: req0 write addr 5 data 0xDEADBEEF at cycle N; req1 read addr 5 at N+1 -> rvalid[1]=1 at N+2 with rdata=0xDEADBEEF.
- Init: pulse init_start with req=2'b01 held -> init_busy high 16 cycles, writes addr 0..15; init_done pulse at cycle 17; gnt=0 throughout; then all reads return 0.
- Reset mid-init: assert rst_n=0 at sweep addr 7 -> state ST_ARB; no init_done; addr 8..15 keep old data.
- Lock (RAM_ARB_LOCK_EN): req=2'b11, lock=2'b01 for 3 cycles -> gnt=01 three cycles, then 10.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared state encoding and default geometry for ram_access_arbiter and the RAM it fronts.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_ARB  = 2'd0,
      ST_INIT = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   localparam int DEF_NUM_REQ    = 2;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 16;

endpackage

// File: rtl/ram_access_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping, wins.
module rr_pick
   import ram_arb_pkg::*;
#(
   parameter int N     = DEF_NUM_REQ,
   parameter int PTR_W = 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [PTR_W-1:0] winner,
   output logic             any
);

   int unsigned idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int unsigned off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            winner   = PTR_W'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one RAM between NUM_REQ requesters, with an init sweep.
// Optional requester lock enabled by defining RAM_ARB_LOCK_EN.
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int                  NUM_REQ    = DEF_NUM_REQ,
   parameter int                  ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int                  DEPTH      = DEF_DEPTH,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ-1:0]            we,
`ifdef RAM_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]            lock,
`endif
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rvalid,
   output logic [DATA_WIDTH-1:0]         rdata,
   input  logic                          init_start,
   output logic                          init_busy,
   output logic                          init_done,
   output logic [ADDR_WIDTH-1:0]         ram_raddr,
   output logic [ADDR_WIDTH-1:0]         ram_waddr,
   output logic [DATA_WIDTH-1:0]         ram_din,
   output logic                          ram_wen,
   output logic                          ram_ren,
   input  logic [DATA_WIDTH-1:0]         ram_dout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t             state, state_nxt;
   logic [PTR_W-1:0]       rr_ptr;
   logic [PTR_W-1:0]       winner;
   logic [NUM_REQ-1:0]     pick_req, pick_gnt;
   logic                   any;
   logic                   forced;
   logic [ADDR_WIDTH-1:0]  cnt;

`ifdef RAM_ARB_LOCK_EN
   logic                   lock_valid;
   logic [PTR_W-1:0]       lock_owner;

   // A held lock narrows the candidate set to the owner, so the picker grants it alone.
   assign forced   = lock_valid & req[lock_owner] & lock[lock_owner];
   assign pick_req = forced ? (NUM_REQ'(1) << lock_owner) : req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_valid <= 1'b0;
         lock_owner <= '0;
      end else if (state != ST_ARB || state_nxt != ST_ARB) begin
         lock_valid <= 1'b0;
      end else if (any && lock[winner]) begin
         lock_valid <= 1'b1;
         lock_owner <= winner;
      end else begin
         lock_valid <= 1'b0;
      end
   end
`else
   assign forced   = 1'b0;
   assign pick_req = req;
`endif

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req    (pick_req),
      .ptr    (rr_ptr),
      .gnt    (pick_gnt),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      state_nxt = state;
      gnt       = '0;
      ram_wen   = 1'b0;
      ram_ren   = 1'b0;
      ram_waddr = '0;
      ram_raddr = '0;
      ram_din   = '0;
      // Outputs are held quiet while reset is asserted, whatever req shows.
      if (rst_n) begin
         case (state)
            ST_ARB: begin
               gnt = pick_gnt;
               if (any) begin
                  if (we[winner]) begin
                     ram_wen   = 1'b1;
                     ram_waddr = addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                     ram_din   = wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  end else begin
                     ram_ren   = 1'b1;
                     ram_raddr = addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                  end
               end
               if (init_start) state_nxt = ST_INIT;
            end
            ST_INIT: begin
               ram_wen   = 1'b1;
               ram_waddr = cnt;
               ram_din   = INIT_VALUE;
               if (cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_ARB;
            default: state_nxt = ST_ARB;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_ARB;
         rr_ptr <= '0;
         cnt    <= '0;
         rvalid <= '0;
      end else begin
         state  <= state_nxt;
         rvalid <= gnt & ~we;
         cnt    <= (state == ST_INIT) ? cnt + 1'b1 : '0;
         if (state == ST_ARB && any && !forced)
            rr_ptr <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   assign rdata     = ram_dout;
   assign init_busy = (state == ST_INIT);
   assign init_done = (state == ST_DONE);

endmodule
